snake_body: RTL and testbench

SNAKE_BODY -- requirements
Module: snake_body

---
 rtl/snake_pkg.sv | 58 +++++
 rtl/snake_body_if.sv | 35 +++
 rtl/snake_next_head.sv | 58 +++++
 rtl/snake_body.sv | 128 ++++++++++++
 tb/tb_snake_body.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// +------------------------------------------------------------------+
// | snake_pkg : shared types and reset constants for the snake body  |
// | Build option: SNAKE_WRAP_EN (consumed by snake_next_head)        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package snake_pkg;

    localparam int MAX_LEN = 50;
    localparam int LEN_W   = 6;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } seg_t;

    typedef seg_t [MAX_LEN-1:0] body_t;

    localparam seg_t RST_SEG0 = 8'h48;
    localparam seg_t RST_SEG1 = 8'h47;
    localparam seg_t RST_SEG2 = 8'h46;
    localparam seg_t RST_SEG3 = 8'h45;
    localparam dir_t RST_DIR  = DOWN;
    localparam logic [LEN_W-1:0] RST_LEN = 6'd4;

    // Opposite directions differ only in bit 0 of the encoding.
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction

    function automatic body_t rst_body();
        body_t b;
        b    = '0;
        b[0] = RST_SEG0;
        b[1] = RST_SEG1;
        b[2] = RST_SEG2;
        b[3] = RST_SEG3;
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/snake_body_if.sv
// +------------------------------------------------------------------+
// | snake_body_if : control strobes and body state of the snake      |
// | Build option: SNAKE_WRAP_EN (no effect on this interface)        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface snake_body_if;
    import snake_pkg::*;

    logic                      s_reset;
    logic                      start;
    logic                      tick;
    dir_t                      dir_req;
    logic                      goodColl;
    logic [MAX_LEN-1:0][7:0]   body;
    logic [LEN_W-1:0]          length;
    logic [3:0]                head_x;
    logic [3:0]                head_y;
    logic                      badColl;
    logic                      full;

    modport master (
        output s_reset, start, tick, dir_req, goodColl,
        input  body, length, head_x, head_y, badColl, full
    );

    modport slave (
        input  s_reset, start, tick, dir_req, goodColl,
        output body, length, head_x, head_y, badColl, full
    );

endinterface

`default_nettype wire

// File: rtl/snake_next_head.sv
// +------------------------------------------------------------------+
// | snake_next_head : one-step head advance and wall detection       |
// | Build option: SNAKE_WRAP_EN wraps at the walls instead of dying  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module snake_next_head
    import snake_pkg::*;
#(
    parameter int GRID_W = 14,
    parameter int GRID_H = 10
) (
    input  seg_t  head_i,
    input  dir_t  dir_i,
    output seg_t  next_o,
    output logic  wall_o
);

    localparam logic [4:0] C_W_LIM = 5'(GRID_W);
    localparam logic [4:0] C_H_LIM = 5'(GRID_H);
`ifdef SNAKE_WRAP_EN
    localparam logic [3:0] C_X_MAX = 4'(GRID_W - 1);
    localparam logic [3:0] C_Y_MAX = 4'(GRID_H - 1);
`endif

    logic [3:0] w_x;
    logic [3:0] w_y;
    logic       w_x_out;
    logic       w_y_out;

    always_comb begin
        w_x = head_i.x;
        w_y = head_i.y;
        case (dir_i)
            UP:      w_y = head_i.y - 4'd1;
            DOWN:    w_y = head_i.y + 4'd1;
            LEFT:    w_x = head_i.x - 4'd1;
            default: w_x = head_i.x + 4'd1;
        endcase

        // 4-bit wrap-around of 0-1 lands on 15, which is caught here too.
        w_x_out = ({1'b0, w_x} >= C_W_LIM);
        w_y_out = ({1'b0, w_y} >= C_H_LIM);

`ifdef SNAKE_WRAP_EN
        if (w_x_out) w_x = (dir_i == LEFT) ? C_X_MAX : 4'd0;
        if (w_y_out) w_y = (dir_i == UP)   ? C_Y_MAX : 4'd0;
        wall_o = 1'b0;
`else
        wall_o = w_x_out | w_y_out;
`endif
        next_o = '{x: w_x, y: w_y};
    end

endmodule

`default_nettype wire

// File: rtl/snake_body.sv
// +------------------------------------------------------------------+
// | snake_body : snake segment shift register, growth and collision  |
// | Build option: SNAKE_WRAP_EN (wall wrap, see snake_next_head)     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module snake_body
    import snake_pkg::*;
#(
    parameter int GRID_W = 14,
    parameter int GRID_H = 10
) (
    input  wire logic      clk,
    input  wire logic      reset,
    snake_body_if.slave    bus
);

    state_t            state_q,  state_d;
    dir_t              dir_q,    dir_d;
    body_t             body_q,   body_d;
    logic [LEN_W-1:0]  length_q, length_d;
    logic              bad_q,    bad_d;
    logic              grow_q,   grow_d;

    seg_t              w_next;
    logic              w_wall;
    logic              w_grow_ok;
    logic              w_self;

    snake_next_head #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_next_head (
        .head_i (body_q[0]),
        .dir_i  (dir_q),
        .next_o (w_next),
        .wall_o (w_wall)
    );

    // A coincident apple pulse counts for the tick it arrives with.
    assign w_grow_ok = (grow_q | bus.goodColl) && (length_q < LEN_MAX);

    // The tail cell is vacated on a plain move, so it only blocks when growing.
    always_comb begin
        w_self = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (body_q[i] == w_next &&
                ((6'(i) + 6'd2 <= length_q) || (w_grow_ok && (6'(i) + 6'd1 == length_q))))
                w_self = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        body_d   = body_q;
        length_d = length_q;
        bad_d    = bad_q;
        grow_d   = grow_q;

        case (state_q)
            IDLE: begin
                if (bus.start) state_d = RUN;
            end
            RUN: begin
                if (bus.dir_req != reverse_dir(dir_q)) dir_d = bus.dir_req;
                if (bus.goodColl) grow_d = 1'b1;
                if (bus.tick) begin
                    if (w_wall || w_self) begin
                        state_d = DEAD;
                        bad_d   = 1'b1;
                    end else begin
                        for (int i = 1; i < MAX_LEN; i++) begin
                            if ((6'(i) < length_q) || (w_grow_ok && (6'(i) == length_q)))
                                body_d[i] = body_q[i-1];
                        end
                        body_d[0] = w_next;
                        if (w_grow_ok) length_d = length_q + 6'd1;
                        grow_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase

        if (bus.s_reset) begin
            state_d  = IDLE;
            dir_d    = RST_DIR;
            body_d   = rst_body();
            length_d = RST_LEN;
            bad_d    = 1'b0;
            grow_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            dir_q    <= RST_DIR;
            body_q   <= rst_body();
            length_q <= RST_LEN;
            bad_q    <= 1'b0;
            grow_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            body_q   <= body_d;
            length_q <= length_d;
            bad_q    <= bad_d;
            grow_q   <= grow_d;
        end
    end

    always_comb begin
        for (int i = 0; i < MAX_LEN; i++)
            bus.body[i] = (6'(i) < length_q) ? body_q[i] : 8'h00;
    end

    assign bus.length  = length_q;
    assign bus.head_x  = body_q[0].x;
    assign bus.head_y  = body_q[0].y;
    assign bus.badColl = bad_q;
    assign bus.full    = (length_q == LEN_MAX);

endmodule

`default_nettype wire

// File: tb/tb_snake_body.sv
// +------------------------------------------------------------------+
// | tb_snake_body : directed scoreboard bench for snake_body         |
// | Build option: SNAKE_WRAP_EN selects the wrap-mode wall results   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_snake_body;
    import snake_pkg::*;

    typedef struct {
        bit           chk_body;
        logic [399:0] body;
        logic [5:0]   len;
        logic         bad;
        logic         full;
        logic [7:0]   head;
    } exp_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    exp_t  exp_q[$];
    string name_q[$];

    snake_body_if bus();

    snake_body #(
        .GRID_W (14),
        .GRID_H (10)
    ) dut (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input string f,
                       input logic [399:0] act, input logic [399:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%0h expected=%0h", n, f, act, exp);
        end
    endtask

    task automatic push(input string n, input bit cb, input logic [399:0] b,
                        input logic [5:0] l, input logic bd, input logic fl,
                        input logic [7:0] h);
        exp_t e;
        e.chk_body = cb;
        e.body     = b;
        e.len      = l;
        e.bad      = bd;
        e.full     = fl;
        e.head     = h;
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs settle after each posedge; compare on the falling edge.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                chk(n, "head",    400'({bus.head_x, bus.head_y}), 400'(e.head));
                chk(n, "length",  400'(bus.length),  400'(e.len));
                chk(n, "badColl", 400'(bus.badColl), 400'(e.bad));
                chk(n, "full",    400'(bus.full),    400'(e.full));
                if (e.chk_body) chk(n, "body", bus.body, e.body);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    localparam logic [399:0] RST_B = 400'({8'h45, 8'h46, 8'h47, 8'h48});

    dir_t path_dir[7] = '{DOWN, LEFT, UP, RIGHT, DOWN, LEFT, UP};
    int   path_cnt[7] = '{1, 4, 9, 13, 9, 8, 2};

    initial begin
        int k;
        checks      = 0;
        failures    = 0;
        reset_n     = 1'b0;
        bus.s_reset = 1'b0;
        bus.start   = 1'b0;
        bus.tick    = 1'b0;
        bus.goodColl = 1'b0;
        bus.dir_req = DOWN;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        push("reset", 1, RST_B, 6'd4, 0, 0, 8'h48);

        // Tick, apple and turn while IDLE must all be ignored.
        bus.tick = 1; bus.goodColl = 1; bus.dir_req = RIGHT;
        step();
        bus.tick = 0; bus.goodColl = 0;
        push("idle_tick", 1, RST_B, 6'd4, 0, 0, 8'h48);

        bus.start = 1; bus.dir_req = UP;
        step();
        bus.start = 0;
        step();
        bus.tick = 1;
        step();
        bus.tick = 0;
        push("first_tick_rev_ignored", 1, 400'({8'h46, 8'h47, 8'h48, 8'h49}), 6'd4, 0, 0, 8'h49);

        bus.dir_req = RIGHT; step();
        bus.tick = 1; step(); bus.tick = 0;
        push("turn_right", 1, 400'({8'h47, 8'h48, 8'h49, 8'h59}), 6'd4, 0, 0, 8'h59);

        bus.goodColl = 1; step(); bus.goodColl = 0;
        bus.tick = 1; step(); bus.tick = 0;
        push("grow_pending", 1, 400'({8'h47, 8'h48, 8'h49, 8'h59, 8'h69}), 6'd5, 0, 0, 8'h69);

        bus.goodColl = 1; bus.tick = 1; step(); bus.goodColl = 0; bus.tick = 0;
        push("grow_same_cycle", 1, 400'({8'h47, 8'h48, 8'h49, 8'h59, 8'h69, 8'h79}), 6'd6, 0, 0, 8'h79);

        bus.dir_req = UP; step();
        bus.tick = 1; step(); bus.tick = 0;
        push("turn_up", 1, 400'({8'h48, 8'h49, 8'h59, 8'h69, 8'h79, 8'h78}), 6'd6, 0, 0, 8'h78);

        bus.dir_req = LEFT; step();
        bus.tick = 1; step(); bus.tick = 0;
        push("turn_left", 1, 400'({8'h49, 8'h59, 8'h69, 8'h79, 8'h78, 8'h68}), 6'd6, 0, 0, 8'h68);

        bus.dir_req = DOWN; step();
        bus.tick = 1; step(); bus.tick = 0;
        push("self_hit", 1, 400'({8'h49, 8'h59, 8'h69, 8'h79, 8'h78, 8'h68}), 6'd6, 1, 0, 8'h68);

        bus.tick = 1; bus.goodColl = 1; bus.dir_req = RIGHT; step();
        bus.tick = 0; bus.goodColl = 0;
        push("dead_frozen", 1, 400'({8'h49, 8'h59, 8'h69, 8'h79, 8'h78, 8'h68}), 6'd6, 1, 0, 8'h68);

        bus.s_reset = 1; step(); bus.s_reset = 0;
        push("soft_reset", 1, RST_B, 6'd4, 0, 0, 8'h48);
        bus.tick = 1; step(); bus.tick = 0;
        push("idle_after_sreset", 1, RST_B, 6'd4, 0, 0, 8'h48);

        // Run right into the x wall.
        bus.start = 1; bus.dir_req = RIGHT; step();
        bus.start = 0; step();
        bus.tick = 1;
        repeat (9) step();
        bus.tick = 0;
        push("at_x13", 1, 400'({8'hA8, 8'hB8, 8'hC8, 8'hD8}), 6'd4, 0, 0, 8'hD8);
        bus.tick = 1; step(); bus.tick = 0;
`ifdef SNAKE_WRAP_EN
        push("wall_wrap", 1, 400'({8'hB8, 8'hC8, 8'hD8, 8'h08}), 6'd4, 0, 0, 8'h08);
`else
        push("wall_hit", 1, 400'({8'hA8, 8'hB8, 8'hC8, 8'hD8}), 6'd4, 1, 0, 8'hD8);
`endif

        bus.s_reset = 1; bus.tick = 1; bus.goodColl = 1; step();
        bus.s_reset = 0; bus.tick = 0; bus.goodColl = 0;
        push("sreset_over_tick", 1, RST_B, 6'd4, 0, 0, 8'h48);

        // Grow on every move along a perimeter path up to 50 segments.
        bus.start = 1; step(); bus.start = 0;
        k = 0;
        for (int s = 0; s < 7; s++) begin
            for (int c = 0; c < path_cnt[s]; c++) begin
                bus.dir_req = path_dir[s]; step();
                bus.tick = 1; bus.goodColl = 1; step();
                bus.tick = 0; bus.goodColl = 0;
                k++;
                if (k == 45) push("len49", 0, '0, 6'd49, 0, 0, 8'h58);
            end
        end
        push("len50", 0, '0, 6'd50, 0, 1, 8'h57);

        bus.dir_req = UP; bus.tick = 1; bus.goodColl = 1; step();
        bus.tick = 0; bus.goodColl = 0;
        push("full_no_grow", 0, '0, 6'd50, 0, 1, 8'h56);
        step();
        push("full_pending_dropped", 0, '0, 6'd50, 0, 1, 8'h56);

        for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
